quick_spi_target: RTL and testbench



---
 rtl/quick_spi_target.sv | 116 +++++++++++
 tb/tb_quick_spi_target.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi_target.sv
// quick_spi_target: oversampled SPI target (SCLK idle high, MSB first) with one-entry TX buffer.
// Optional sticky underrun flag enabled by QUICK_SPI_TARGET_UNDERRUN_EN.
module quick_spi_target #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sclk_i,
  input  logic                             cs_n_i,
  input  logic                             sdata_i,
  output logic                             sdata_o,
  output logic                             sdata_oe_o,
  input  logic [DATA_WIDTH-1:0]            tx_data_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  output logic [DATA_WIDTH-1:0]            rx_data_o,
  output logic [$clog2(DATA_WIDTH+1)-1:0]  rx_count_o,
  output logic                             rx_valid_o,
  output logic                             frame_active_o,
  output logic                             tx_underrun_o
);
  localparam int CW = $clog2(DATA_WIDTH+1);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, sd_q, vld_q;
  logic [DATA_WIDTH-1:0] buf_q, tx_shift, rx_shift;
  logic [CW-1:0] bit_cnt;
  logic sclk_d, armed, buf_full;
  logic sclk_s, cs_s, sd_s, rise, fall, last, ld;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign sd_s = sd_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;
  assign last = bit_cnt == CW'(DATA_WIDTH-1);
  assign ld = (state == LOAD) || (state == ACTIVE && !cs_s && rise && last);
  assign tx_ready_o = !buf_full;
  assign sdata_oe_o = frame_active_o;
  // armed blocks a frame already in progress at reset release until CS is seen high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q <= '1;
      cs_q <= '1;
      sd_q <= '1;
      vld_q <= '0;
      sclk_d <= 1'b1;
      armed <= 1'b0;
      state <= IDLE;
      buf_q <= '0;
      buf_full <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      sdata_o <= 1'b0;
      frame_active_o <= 1'b0;
      rx_data_o <= '0;
      rx_count_o <= '0;
      rx_valid_o <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q <= {cs_q[SYNC_STAGES-2:0], cs_n_i};
      sd_q <= {sd_q[SYNC_STAGES-2:0], sdata_i};
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d <= sclk_s;
      armed <= armed | (vld_q[SYNC_STAGES-1] & cs_s);
      frame_active_o <= !cs_s;
      rx_valid_o <= 1'b0;
      if (ld) begin
        tx_shift <= buf_full ? buf_q : '0;
        buf_full <= 1'b0;
      end else if (tx_valid_i && !buf_full) begin
        buf_q <= tx_data_i;
        buf_full <= 1'b1;
      end
      case (state)
        IDLE: state <= (armed && !cs_s) ? LOAD : IDLE;
        LOAD: begin
          bit_cnt <= '0;
          rx_shift <= '0;
          state <= ACTIVE;
        end
        default: begin
          if (cs_s) begin
            if (bit_cnt != '0) begin
              rx_data_o <= rx_shift;
              rx_count_o <= bit_cnt;
              rx_valid_o <= 1'b1;
            end
            state <= IDLE;
          end else if (fall) begin
            sdata_o <= tx_shift[DATA_WIDTH-1];
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end else if (rise && last) begin
            rx_data_o <= {rx_shift[DATA_WIDTH-2:0], sd_s};
            rx_count_o <= CW'(DATA_WIDTH);
            rx_valid_o <= 1'b1;
            rx_shift <= '0;
            bit_cnt <= '0;
          end else if (rise) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], sd_s};
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      endcase
    end
  end
`ifdef QUICK_SPI_TARGET_UNDERRUN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tx_underrun_o <= 1'b0;
    else if (ld && !buf_full) tx_underrun_o <= 1'b1;
  end
`else
  assign tx_underrun_o = 1'b0;
`endif
endmodule

// File: tb/tb_quick_spi_target.sv
// tb_quick_spi_target: scoreboard bench driving quick_spi_target as an SPI controller.
module tb_quick_spi_target;
  localparam int H = 6;
`ifdef QUICK_SPI_TARGET_UNDERRUN_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif
  logic clk_i = 0, rst_i = 1, sclk_i = 1, cs_n_i = 1, sdata_i = 0, tx_valid_i = 0;
  logic [15:0] tx_data_i = '0;
  logic sdata_o, sdata_oe_o, tx_ready_o, rx_valid_o, frame_active_o, tx_underrun_o;
  logic [15:0] rx_data_o;
  logic [4:0] rx_count_o;
  int checks = 0, errors = 0;
  logic [15:0] tx_q[$], late_q[$];
  logic [20:0] exp_rx[$], got_rx[$];
  time got_t[$];
  logic rdy_load, fire = 0;
  logic [63:0] m;
  logic [20:0] g, e;

  quick_spi_target dut (
    .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .cs_n_i(cs_n_i), .sdata_i(sdata_i),
    .sdata_o(sdata_o), .sdata_oe_o(sdata_oe_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_count_o(rx_count_o),
    .rx_valid_o(rx_valid_o), .frame_active_o(frame_active_o), .tx_underrun_o(tx_underrun_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // ready sampled at a negedge equals ready just before the following posedge
  initial forever begin
    @(negedge clk_i);
    if (fire) begin tx_valid_i = 0; fire = 0; end
    if (!tx_valid_i && tx_q.size() > 0) begin tx_data_i = tx_q.pop_front(); tx_valid_i = 1; end
    fire = tx_valid_i && tx_ready_o;
  end

  always @(negedge clk_i)
    if (rx_valid_o) begin got_rx.push_back({rx_data_o, rx_count_o}); got_t.push_back($time); end

  task automatic preload(input logic [15:0] w);
    tx_q.push_back(w);
    for (int i = 0; i < 20 && tx_ready_o; i++) @(negedge clk_i);
    checks++;
    if (tx_ready_o !== 1'b0) begin errors++; $display("FAIL preload tx_ready got %b want 0", tx_ready_o); end
  endtask

  task automatic spi_begin();
    @(negedge clk_i);
    cs_n_i = 0;
    repeat (8) @(negedge clk_i);
    rdy_load = tx_ready_o;
    while (late_q.size() > 0) tx_q.push_back(late_q.pop_front());
  endtask

  task automatic spi_bits(input int n, input logic [63:0] mosi, output logic [63:0] miso);
    miso = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sclk_i = 0;
      sdata_i = mosi[i];
      repeat (H) @(negedge clk_i);
      sclk_i = 1;
      miso = {miso[62:0], sdata_o};
      repeat (H) @(negedge clk_i);
    end
  endtask

  task automatic spi_end();
    cs_n_i = 1;
    repeat (10) @(negedge clk_i);
  endtask

  task automatic spi_frame(input int n, input logic [63:0] mosi, output logic [63:0] miso);
    spi_begin();
    spi_bits(n, mosi, miso);
    spi_end();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if ({sdata_o, sdata_oe_o, frame_active_o, rx_valid_o, tx_underrun_o, tx_ready_o} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags got %b want 000001", {sdata_o, sdata_oe_o, frame_active_o, rx_valid_o, tx_underrun_o, tx_ready_o});
    end
    checks++;
    if ({rx_data_o, rx_count_o} !== 21'h0) begin errors++; $display("FAIL reset_rx got %h want 0", {rx_data_o, rx_count_o}); end
    rst_i = 0;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic test_single();
    got_rx.delete();
    preload(16'hA55A);
    late_q.push_back(16'h0000);
    exp_rx.push_back({16'h1234, 5'd16});
    spi_frame(16, 64'h1234, m);
    checks++;
    if (rdy_load !== 1'b1) begin errors++; $display("FAIL single_ready_after_load got %b want 1", rdy_load); end
    checks++;
    if (m[15:0] !== 16'hA55A) begin errors++; $display("FAIL single_miso got %h want a55a", m[15:0]); end
    checks++;
    if (got_rx.size() != exp_rx.size()) begin errors++; $display("FAIL single_strobes got %0d want %0d", got_rx.size(), exp_rx.size()); end
    while (got_rx.size() > 0 && exp_rx.size() > 0) begin
      g = got_rx.pop_front(); e = exp_rx.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL single_rx got %h want %h", g, e); end
    end
    exp_rx.delete();
  endtask

  task automatic test_short();
    got_rx.delete();
    preload(16'h9C00);
    exp_rx.push_back({16'h0016, 5'd5});
    spi_frame(5, 64'b10110, m);
    checks++;
    if (m[4:0] !== 5'b10011) begin errors++; $display("FAIL short_miso got %b want 10011", m[4:0]); end
    checks++;
    if (got_rx.size() != exp_rx.size()) begin errors++; $display("FAIL short_strobes got %0d want %0d", got_rx.size(), exp_rx.size()); end
    while (got_rx.size() > 0 && exp_rx.size() > 0) begin
      g = got_rx.pop_front(); e = exp_rx.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL short_rx got %h want %h", g, e); end
    end
    exp_rx.delete();
  endtask

  task automatic test_back_to_back();
    got_rx.delete(); got_t.delete();
    preload(16'hBEEF);
    late_q.push_back(16'hCAFE);
    late_q.push_back(16'h0000);
    exp_rx.push_back({16'h1357, 5'd16});
    exp_rx.push_back({16'h9BDF, 5'd16});
    spi_frame(32, 64'h1357_9BDF, m);
    checks++;
    if (m[31:0] !== 32'hBEEF_CAFE) begin errors++; $display("FAIL b2b_miso got %h want beefcafe", m[31:0]); end
    checks++;
    if (got_t.size() != 2 || got_t[1] - got_t[0] != 16 * 2 * H * 10) begin
      errors++;
      $display("FAIL b2b_spacing got %0d strobes want 2 spaced %0d", got_t.size(), 16 * 2 * H * 10);
    end
    checks++;
    if (got_rx.size() != exp_rx.size()) begin errors++; $display("FAIL b2b_strobes got %0d want %0d", got_rx.size(), exp_rx.size()); end
    while (got_rx.size() > 0 && exp_rx.size() > 0) begin
      g = got_rx.pop_front(); e = exp_rx.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_rx got %h want %h", g, e); end
    end
    exp_rx.delete();
  endtask

  task automatic test_idle_return();
    got_rx.delete();
    preload(16'h6DB6);
    late_q.push_back(16'h8000);
    exp_rx.push_back({16'hF00D, 5'd16});
    exp_rx.push_back({16'h0001, 5'd1});
    spi_frame(17, 64'h1E01B, m);
    checks++;
    if (m[16:0] !== 17'h0DB6D) begin errors++; $display("FAIL idle_miso got %h want 0db6d", m[16:0]); end
    checks++;
    if (got_rx.size() != exp_rx.size()) begin errors++; $display("FAIL idle_strobes got %0d want %0d", got_rx.size(), exp_rx.size()); end
    while (got_rx.size() > 0 && exp_rx.size() > 0) begin
      g = got_rx.pop_front(); e = exp_rx.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL idle_rx got %h want %h", g, e); end
    end
    exp_rx.delete();
  endtask

  task automatic test_underrun();
    got_rx.delete();
    checks++;
    if (tx_underrun_o !== 1'b0) begin errors++; $display("FAIL underrun_pre got %b want 0", tx_underrun_o); end
    exp_rx.push_back({16'h7777, 5'd16});
    spi_frame(16, 64'h7777, m);
    checks++;
    if (m[15:0] !== 16'h0000) begin errors++; $display("FAIL underrun_miso got %h want 0000", m[15:0]); end
    checks++;
    if (tx_underrun_o !== EXP_UR) begin errors++; $display("FAIL underrun_flag got %b want %b", tx_underrun_o, EXP_UR); end
    checks++;
    if (got_rx.size() != exp_rx.size()) begin errors++; $display("FAIL underrun_strobes got %0d want %0d", got_rx.size(), exp_rx.size()); end
    while (got_rx.size() > 0 && exp_rx.size() > 0) begin
      g = got_rx.pop_front(); e = exp_rx.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL underrun_rx got %h want %h", g, e); end
    end
    exp_rx.delete();
  endtask

  task automatic test_reset_mid();
    got_rx.delete();
    preload(16'hFFFF);
    late_q.push_back(16'h1111);
    spi_begin();
    spi_bits(7, 64'h55, m);
    checks++;
    if ({sdata_o, tx_ready_o} !== 2'b10) begin errors++; $display("FAIL mid_pre got %b want 10", {sdata_o, tx_ready_o}); end
    rst_i = 1;
    #1;
    checks++;
    if ({sdata_o, sdata_oe_o, frame_active_o, rx_valid_o, tx_underrun_o, tx_ready_o, rx_data_o, rx_count_o} !== {6'b000001, 21'h0}) begin
      errors++;
      $display("FAIL mid_reset got %h want %h", {sdata_o, sdata_oe_o, frame_active_o, rx_valid_o, tx_underrun_o, tx_ready_o, rx_data_o, rx_count_o}, {6'b000001, 21'h0});
    end
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    spi_bits(4, 64'hF, m);
    spi_end();
    checks++;
    if (got_rx.size() != 0) begin errors++; $display("FAIL mid_no_strobe got %0d want 0", got_rx.size()); end
    got_rx.delete();
    preload(16'hC3A5);
    late_q.push_back(16'h0000);
    exp_rx.push_back({16'h0F0F, 5'd16});
    spi_frame(16, 64'h0F0F, m);
    checks++;
    if (m[15:0] !== 16'hC3A5) begin errors++; $display("FAIL mid_next_miso got %h want c3a5", m[15:0]); end
    checks++;
    if (got_rx.size() != exp_rx.size()) begin errors++; $display("FAIL mid_next_strobes got %0d want %0d", got_rx.size(), exp_rx.size()); end
    while (got_rx.size() > 0 && exp_rx.size() > 0) begin
      g = got_rx.pop_front(); e = exp_rx.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL mid_next_rx got %h want %h", g, e); end
    end
    exp_rx.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_short();
    test_back_to_back();
    test_idle_return();
    test_underrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
